uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 2604, meaning clk cycles per serial bit (50 MHz / 2 half-rate clock, 9600 baud); legal values are even and >= 4.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx  input  1  serial line, idle high, 8N1 frame, LSB first; asynchronous to clk.
REQ-005 rx_data  output  8  last correctly received byte.
REQ-006 rx_valid  output  1  high while rx_data holds an unacknowledged byte.
REQ-007 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-008 overrun  output  1  sticky: a byte completed while rx_valid was already set.
REQ-009 framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1, before any use; rx_s denotes its output.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 IDLE: when rx_s==0, go to START with bit counter cleared; T0 is this edge.
REQ-014 START: at count CLKS_PER_BIT/2-1, sample rx_s; if 0, go to DATA with counter cleared; if 1 (glitch), return to IDLE with no output change.
REQ-015 DATA: at count CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (LSB-first reception) and clear the counter; after the 8th sample, go to STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1, sample rx_s; if 1, load rx_data from the shift register, set rx_valid, and go to IDLE.
REQ-017 STOP: if the sampled rx_s is 0, pulse framing_error for exactly one cycle, leave rx_data/rx_valid unchanged, and go to WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s==1, then go to IDLE, so a break is not decoded as a new start.
REQ-019 rx_valid SHALL rise at T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles; with CLKS_PER_BIT=16 that is T0+152.
REQ-020 rx_ack while rx_valid==1 SHALL clear rx_valid and overrun on the next edge; rx_ack while rx_valid==0 SHALL have no effect.
REQ-021 If a byte completes while rx_valid==1 and rx_ack==0, rx_data SHALL be overwritten with the new byte, rx_valid SHALL stay 1, and overrun SHALL set.
REQ-022 If a byte completes in the same cycle as rx_ack, rx_data SHALL load the new byte, rx_valid SHALL stay 1, and overrun SHALL be cleared (acknowledge wins for the old byte).
REQ-023 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL never exceed CLKS_PER_BIT-1, and SHALL wrap to 0 on each sample.
REQ-024 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-025 While reset==0: FSM=IDLE, counter=0, shift register=0, rx_data=8'h00, rx_valid=0, overrun=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no partial rx_data update; after release the block SHALL wait for a new falling edge on rx_s.

Verification (CLKS_PER_BIT=16)
REQ-027 Send frame 0xA5, rx_ack held 0 -> rx_valid rises at T0+152, rx_data=0xA5, overrun=0, framing_error never pulses.
REQ-028 Low glitch on rx lasting 4 clk cycles in IDLE -> START entered then IDLE re-entered by T0+8; rx_valid stays 0, busy returns to 0.
REQ-029 Send 0x3C with the stop bit driven 0, then hold rx low for 40 cycles -> framing_error is high for exactly 1 cycle, rx_valid=0, busy=1 until rx returns high, and no new start is detected meanwhile.
REQ-030 Send 0x11 then 0x22 back-to-back with no rx_ack -> rx_data=0x22, rx_valid=1, overrun=1; pulse rx_ack once -> rx_valid=0 and overrun=0 on the next edge.
REQ-031 Send 0x55, and assert rx_ack exactly in the cycle 0x66 completes -> rx_data=0x66, rx_valid=1, overrun=0.
REQ-032 Assert reset during bit 4 of 0xFF, release it, then send 0x81 -> rx_data remains 0x00 until 0x81 is received; rx_valid asserts only for 0x81.

Source files
------------

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronizes rx, centre-samples each bit and hands the
// byte to a consumer through a valid/acknowledge pair with overrun detection.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            fe_q, fe_d;
  logic            busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      fe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      fe_q       <= fe_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, bit timing and consumer handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    fe_d       = 1'b0;

    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        bit_d = 3'd0;
        if (!rx_s_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = CNT_ZERO;
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = CNT_ZERO;
          if (rx_s_q) begin
            // An acknowledge in this same cycle retires the old byte, so no overrun.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = overrun_d | (rx_valid_q & ~rx_ack);
            state_d    = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        cnt_d = CNT_ZERO;
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;
  assign framing_error = fe_q;
  assign busy          = busy_q;

endmodule
